// File: rtl/bimux_pkg.sv
// Shared definitions for the bidirectional steering switch.
//   state_e            : route FSM states
//   DIR_NORMAL/REVERSE : transfer direction encodings
//   TURN_W             : width of the turnaround down-counter
package bimux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam logic DIR_NORMAL  = 1'b0;   // channel -> common
    localparam logic DIR_REVERSE = 1'b1;   // common -> channel

    localparam int TURN_W = 4;

endpackage

// File: rtl/bimux_switch_if.sv
// Bus bundle between a requester and the steering switch.
//   slave  : switch side (request/data in, grant/enables/drive values out)
//   master : requester / pad side
interface bimux_switch_if #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = 16
);
    logic             req;
    logic             dir;
    logic [SEL_W-1:0] sel;
    logic             grant;
    logic             err;
    logic [W-1:0]     com_i;
    logic [W-1:0]     com_o;
    logic             com_oe;
    logic [N*W-1:0]   ch_i;
    logic [N*W-1:0]   ch_o;
    logic [N-1:0]     ch_oe;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  req, dir, sel, com_i, ch_i,
        output grant, err, com_o, com_oe, ch_o, ch_oe, beat_cnt
    );

    modport master (
        output req, dir, sel, com_i, ch_i,
        input  grant, err, com_o, com_oe, ch_o, ch_oe, beat_cnt
    );
endinterface

// File: rtl/bimux_route_fsm.sv
// Route controller: request legality, dir/sel latching, turnaround gap and
// registered grant/err/enable generation.
//   req_i/dir_i/sel_i : route request inputs
//   grant_o, err_o    : route live / one-cycle illegal-select pulse
//   com_oe_o, ch_oe_o : registered output enables (mutually exclusive)
//   live_nx_o, dir_nx_o, sel_nx_o : next-cycle route, lets the data
//                       registers load in step with the enables
//
// state  | meaning
// IDLE   | no route, waiting for a legal request
// TURN   | route latched, all enables low for TURN_CYC cycles
// ACTIVE | route live, one side enabled, data flowing
module bimux_route_fsm
    import bimux_pkg::*;
#(
    parameter int N        = 8,
    parameter int SEL_W    = $clog2(N),
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             dir_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic             grant_o,
    output logic             err_o,
    output logic             com_oe_o,
    output logic [N-1:0]     ch_oe_o,
    output logic             live_nx_o,
    output logic             dir_nx_o,
    output logic [SEL_W-1:0] sel_nx_o
);

    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              err_q, err_d;
    logic              grant_q, grant_d;
    logic              com_oe_q, com_oe_d;
    logic [N-1:0]      ch_oe_q, ch_oe_d;

    logic sel_ok;
    logic route_chg;

    assign sel_ok    = int'(sel_i) < N;
    assign route_chg = (dir_i != dir_q) || (sel_i != sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            sel_q    <= '0;
            turn_q   <= '0;
            err_q    <= 1'b0;
            grant_q  <= 1'b0;
            com_oe_q <= 1'b0;
            ch_oe_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            sel_q    <= sel_d;
            turn_q   <= turn_d;
            err_q    <= err_d;
            grant_q  <= grant_d;
            com_oe_q <= com_oe_d;
            ch_oe_q  <= ch_oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        sel_d   = sel_q;
        turn_d  = turn_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (sel_ok) begin
                        state_d = TURN;
                        dir_d   = dir_i;
                        sel_d   = sel_i;
                        turn_d  = TURN_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            TURN: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (turn_q == '0) begin
                    state_d = ACTIVE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            ACTIVE: begin
                if (!req_i) begin
                    state_d = IDLE;
                end else if (route_chg) begin
                    // A changed route while live is a fresh request.
                    if (sel_ok) begin
                        state_d = TURN;
                        dir_d   = dir_i;
                        sel_d   = sel_i;
                        turn_d  = TURN_LOAD;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next state so they register on the very
    // edge that enters ACTIVE and drop on the edge that leaves it.
    always_comb begin
        grant_d  = (state_d == ACTIVE);
        com_oe_d = grant_d && (dir_d == DIR_NORMAL);
        ch_oe_d  = '0;
        for (int k = 0; k < N; k++) begin
            ch_oe_d[k] = grant_d && (dir_d == DIR_REVERSE) && (sel_d == SEL_W'(k));
        end
    end

    assign grant_o   = grant_q;
    assign err_o     = err_q;
    assign com_oe_o  = com_oe_q;
    assign ch_oe_o   = ch_oe_q;
    assign live_nx_o = grant_d;
    assign dir_nx_o  = dir_d;
    assign sel_nx_o  = sel_d;

endmodule

// File: rtl/bimux_switch.sv
// Registered bidirectional steering switch between one common bus and N
// endpoint channels. Drives split value/enable outputs for external
// tristate buffers.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave modport carrying request, data and enable signals
module bimux_switch
    import bimux_pkg::*;
#(
    parameter int N        = 8,
    parameter int W        = 8,
    parameter int SEL_W    = $clog2(N),
    parameter int TURN_CYC = 1,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    bimux_switch_if.slave  bus
);

    logic             live_nx;
    logic             dir_nx;
    logic [SEL_W-1:0] sel_nx;
    logic             grant;
    logic             err;
    logic             com_oe;
    logic [N-1:0]     ch_oe;

    logic [W-1:0]     com_o_q, com_o_d;
    logic [N*W-1:0]   ch_o_q, ch_o_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    bimux_route_fsm #(
        .N        (N),
        .SEL_W    (SEL_W),
        .TURN_CYC (TURN_CYC)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req),
        .dir_i     (bus.dir),
        .sel_i     (bus.sel),
        .grant_o   (grant),
        .err_o     (err),
        .com_oe_o  (com_oe),
        .ch_oe_o   (ch_oe),
        .live_nx_o (live_nx),
        .dir_nx_o  (dir_nx),
        .sel_nx_o  (sel_nx)
    );

    // Data loads alongside the enables, so a driven value is valid in the
    // same cycle its enable rises; idle drive values are held at zero.
    always_comb begin
        com_o_d = '0;
        ch_o_d  = '0;
        for (int k = 0; k < N; k++) begin
            if (live_nx && (sel_nx == SEL_W'(k))) begin
                if (dir_nx == DIR_NORMAL) begin
                    com_o_d = bus.ch_i[k*W +: W];
                end else begin
                    ch_o_d[k*W +: W] = bus.com_i;
                end
            end
        end
        beat_d = '0;
        if (live_nx) begin
            beat_d = (&beat_q) ? beat_q : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            com_o_q <= '0;
            ch_o_q  <= '0;
            beat_q  <= '0;
        end else begin
            com_o_q <= com_o_d;
            ch_o_q  <= ch_o_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.grant    = grant;
    assign bus.err      = err;
    assign bus.com_oe   = com_oe;
    assign bus.ch_oe    = ch_oe;
    assign bus.com_o    = com_o_q;
    assign bus.ch_o     = ch_o_q;
    assign bus.beat_cnt = beat_q;

endmodule

// File: tb/tb_bimux_switch.sv
// Testbench for bimux_switch. Three instances share one stimulus stream:
//   u_a : N=8, TURN_CYC=1, CNT_W=16  (table-driven main function)
//   u_b : N=8, TURN_CYC=3, CNT_W=2   (turnaround gap, beat saturation)
//   u_c : N=6, TURN_CYC=1            (illegal select handling)
module tb_bimux_switch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        dir;
    logic [2:0]  sel;
    logic [7:0]  com_i;
    logic [63:0] ch_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bimux_switch_if #(.N(8), .W(8), .CNT_W(16)) if_a ();
    bimux_switch_if #(.N(8), .W(8), .CNT_W(2))  if_b ();
    bimux_switch_if #(.N(6), .W(8), .CNT_W(16)) if_c ();

    assign if_a.req = req;  assign if_a.dir = dir;  assign if_a.sel = sel;
    assign if_a.com_i = com_i;  assign if_a.ch_i = ch_i;
    assign if_b.req = req;  assign if_b.dir = dir;  assign if_b.sel = sel;
    assign if_b.com_i = com_i;  assign if_b.ch_i = ch_i;
    assign if_c.req = req;  assign if_c.dir = dir;  assign if_c.sel = sel;
    assign if_c.com_i = com_i;  assign if_c.ch_i = ch_i[47:0];

    bimux_switch #(.N(8), .W(8), .TURN_CYC(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    bimux_switch #(.N(8), .W(8), .TURN_CYC(3), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));
    bimux_switch #(.N(6), .W(8), .TURN_CYC(1), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c));

    typedef struct {
        logic        req;
        logic        dir;
        logic [2:0]  sel;
        logic [7:0]  com_i;
        logic [7:0]  ch5;
        logic        grant;
        logic        com_oe;
        logic [7:0]  ch_oe;
        logic [7:0]  com_o;
        logic [63:0] ch_o;
        logic [15:0] beat;
    } vec_t;

    typedef struct {
        logic        grant;
        logic        com_oe;
        logic [7:0]  ch_oe;
        logic [7:0]  com_o;
        logic [63:0] ch_o;
        logic [15:0] beat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input logic [7:0] ch5);
        for (int k = 0; k < 8; k++) begin
            ch_i[k*8 +: 8] = (k == 5) ? ch5 : 8'(8'h10 + k);
        end
    endtask

    task automatic excl(input string name, input logic c_oe, input logic [7:0] c_ch);
        checks++;
        if ((c_oe && (c_ch != 8'h00)) || ($countones(c_ch) > 1)) begin
            failures++;
            $display("FAIL %s actual com_oe=%b ch_oe=%b expected exclusive enables", name, c_oe, c_ch);
        end
    endtask

    always @(negedge clk) begin
        excl("oe_excl_a", if_a.com_oe, if_a.ch_oe);
        excl("oe_excl_b", if_b.com_oe, if_b.ch_oe);
        excl("oe_excl_c", if_c.com_oe, {2'b00, if_c.ch_oe});
    end

    task automatic idle(input int n);
        @(negedge clk);
        req = 1'b0; dir = 1'b0; sel = 3'd0; com_i = 8'h00;
        repeat (n) @(posedge clk);
    endtask

    // Counts cycles with grant low on u_b until grant rises; enables must
    // stay low for every one of them.
    task automatic gap_b(input string name, output int n);
        bit got = 1'b0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (if_b.grant) begin
                got = 1'b1;
                break;
            end
            chk({name, "_gap_oe"}, {if_b.com_oe, if_b.ch_oe}, 9'h000);
            n++;
        end
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout actual=no_grant expected=grant_within_32", name);
        end
    endtask

    initial begin
        exp_t e;
        int   gap;

        rst_n = 1'b0; req = 1'b0; dir = 1'b0; sel = 3'd0; com_i = 8'h00;
        set_ch(8'hA5);

        // {req,dir,sel,com_i,ch5, grant,com_oe,ch_oe,com_o,ch_o,beat}
        tbl.push_back('{1,0,3'd5,8'h00,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,0,3'd5,8'h00,8'hA5, 1,1,8'h00,8'hA5,64'h0,16'd1});
        tbl.push_back('{1,0,3'd5,8'h00,8'hA5, 1,1,8'h00,8'hA5,64'h0,16'd2});
        tbl.push_back('{1,0,3'd5,8'h00,8'h5A, 1,1,8'h00,8'h5A,64'h0,16'd3});
        tbl.push_back('{0,0,3'd5,8'h00,8'h5A, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,1,3'd2,8'h3C,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,1,3'd2,8'h3C,8'hA5, 1,0,8'h04,8'h00,64'h0000_0000_003C_0000,16'd1});
        tbl.push_back('{1,1,3'd2,8'hC3,8'hA5, 1,0,8'h04,8'h00,64'h0000_0000_00C3_0000,16'd2});
        tbl.push_back('{0,1,3'd2,8'hC3,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{0,0,3'd0,8'h00,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,0,3'd1,8'h00,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{0,0,3'd1,8'h00,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{0,0,3'd1,8'h00,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,0,3'd7,8'h5E,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,0,3'd7,8'h5E,8'hA5, 1,1,8'h00,8'h17,64'h0,16'd1});
        tbl.push_back('{1,1,3'd7,8'h5E,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});
        tbl.push_back('{1,1,3'd7,8'h5E,8'hA5, 1,0,8'h80,8'h00,64'h5E00_0000_0000_0000,16'd1});
        tbl.push_back('{0,1,3'd7,8'h5E,8'hA5, 0,0,8'h00,8'h00,64'h0,16'd0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant",  if_a.grant, 1'b0);
        chk("rst_err",    if_a.err, 1'b0);
        chk("rst_oe",     {if_a.com_oe, if_a.ch_oe}, 9'h000);
        chk("rst_data",   {if_a.com_o, if_a.ch_o}, 72'h0);
        chk("rst_beat",   if_a.beat_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            req = tbl[i].req; dir = tbl[i].dir; sel = tbl[i].sel; com_i = tbl[i].com_i;
            set_ch(tbl[i].ch5);
            sb.push_back('{tbl[i].grant, tbl[i].com_oe, tbl[i].ch_oe,
                           tbl[i].com_o, tbl[i].ch_o, tbl[i].beat});
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_grant", i),  if_a.grant, e.grant);
            chk($sformatf("v%0d_err", i),    if_a.err, 1'b0);
            chk($sformatf("v%0d_com_oe", i), if_a.com_oe, e.com_oe);
            chk($sformatf("v%0d_ch_oe", i),  if_a.ch_oe, e.ch_oe);
            chk($sformatf("v%0d_com_o", i),  if_a.com_o, e.com_o);
            chk($sformatf("v%0d_ch_o", i),   if_a.ch_o, e.ch_o);
            chk($sformatf("v%0d_beat", i),   if_a.beat_cnt, e.beat);
        end
        set_ch(8'hA5);
        idle(3);

        // Three-cycle turnaround, 2-bit beat saturation, hot redirect.
        @(negedge clk);
        req = 1'b1; dir = 1'b1; sel = 3'd2; com_i = 8'h3C;
        gap_b("b_first", gap);
        chk("b_first_gap", gap, 3);
        chk("b_first_ch_oe", if_b.ch_oe, 8'h04);
        chk("b_first_com_oe", if_b.com_oe, 1'b0);
        chk("b_first_ch_o", if_b.ch_o, 64'h0000_0000_003C_0000);
        chk("b_beat1", if_b.beat_cnt, 2'd1);
        @(posedge clk); #1; chk("b_beat2", if_b.beat_cnt, 2'd2);
        @(posedge clk); #1; chk("b_beat3", if_b.beat_cnt, 2'd3);
        @(posedge clk); #1; chk("b_beat_sat", if_b.beat_cnt, 2'd3);
        @(negedge clk);
        sel = 3'd6;
        gap_b("b_redir", gap);
        chk("b_redir_gap", gap, 3);
        chk("b_redir_ch_oe", if_b.ch_oe, 8'h40);
        chk("b_redir_ch_o", if_b.ch_o, 64'h003C_0000_0000_0000);
        chk("b_redir_beat", if_b.beat_cnt, 2'd1);
        idle(3);

        // Illegal select held: err every cycle, nothing enabled.
        @(negedge clk);
        req = 1'b1; dir = 1'b0; sel = 3'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("c_ill%0d_err", i), if_c.err, 1'b1);
            chk($sformatf("c_ill%0d_grant", i), if_c.grant, 1'b0);
            chk($sformatf("c_ill%0d_oe", i), {if_c.com_oe, if_c.ch_oe}, 7'h00);
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk("c_ill_release_err", if_c.err, 1'b0);

        // Redirect from a live route to an illegal select.
        @(negedge clk);
        req = 1'b1; dir = 1'b0; sel = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("c_live_grant", if_c.grant, 1'b1);
        chk("c_live_com_o", if_c.com_o, 8'h11);
        @(negedge clk);
        sel = 3'd7;
        @(posedge clk); #1;
        chk("c_redir_err", if_c.err, 1'b1);
        chk("c_redir_grant", if_c.grant, 1'b0);
        chk("c_redir_oe", {if_c.com_oe, if_c.ch_oe}, 7'h00);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk("c_redir_err_clr", if_c.err, 1'b0);
        idle(2);

        // Asynchronous reset while live.
        @(negedge clk);
        req = 1'b1; dir = 1'b0; sel = 3'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_pre_grant", if_a.grant, 1'b1);
        chk("ar_pre_com_oe", if_a.com_oe, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_grant", if_a.grant, 1'b0);
        chk("ar_oe", {if_a.com_oe, if_a.ch_oe}, 9'h000);
        chk("ar_beat", if_a.beat_cnt, 16'd0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ar_after_grant", if_a.grant, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bimux_switch.md
Name: bimux_switch

Overview:
Parametrised, registered bidirectional steering switch between one common bus and N endpoint channels of width W. It is the next generation of the subleq machine's 8x1 bidirectional mux. It adds a request/grant handshake, latched routing, a tristate-safe turnaround gap on every route change, and explicit output-enable generation. The split in/out/oe ports feed pad or top-level tristate buffers; no internal inout.

Parameters:
N, 8, number of endpoint channels (2..64)
W, 8, data width per channel
SEL_W, $clog2(N), width of channel select
TURN_CYC, 1, dead cycles with all enables low on every route change (1..15)
CNT_W, 16, width of beat counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  route request; held high for duration of use
dir  in  1  0 = channel->common (normal), 1 = common->channel (reverse)
sel  in  SEL_W  channel index
grant  out  1  route established, data path live
err  out  1  one-cycle pulse: illegal sel (sel >= N) requested
com_i  in  W  common bus input
com_o  out  W  common bus drive value
com_oe  out  1  common bus output enable
ch_i  in  N*W  channel inputs, channel k at [k*W +: W]
ch_o  out  N*W  channel drive values
ch_oe  out  N  per-channel output enables (at most one high)
beat_cnt  out  CNT_W  cycles spent in ACTIVE on current route, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; grant=0, err=0, com_oe=0, ch_oe=0, com_o=0, ch_o=0, beat_cnt=0, latched dir/sel=0.
- States: IDLE, TURN, ACTIVE.
- IDLE:
  - req=1 and sel<N: latch dir/sel, load turn counter with TURN_CYC-1, go TURN.
  - req=1 and sel>=N: err=1 for exactly one cycle; stay IDLE. err repeats every cycle while the illegal request is held.
- TURN: all oe low, grant=0. Counter decrements; at 0 go ACTIVE. If req drops during TURN, go IDLE.
- ACTIVE: grant=1. Enables are registered and asserted on the first ACTIVE cycle:
  - dir=0: com_oe=1, ch_oe=0.
  - dir=1: ch_oe[sel]=1, com_oe=0.
- Data path latency is 1 cycle:
  - dir=0: com_o <= ch_i[sel].
  - dir=1: ch_o[sel] <= com_i; other ch_o slices hold 0.
- beat_cnt increments each ACTIVE cycle and saturates at all-ones. It clears on entry to TURN or IDLE.
- Leaving ACTIVE:
  - req=0: next state IDLE; grant and all oe low on the next cycle.
  - req=1 with dir or sel differing from the latched values: treated as a new request. Check legality; if legal, re-latch and go TURN with enables dropped next cycle. If illegal, pulse err and go IDLE.
- Invariant: com_oe and any ch_oe are never high in the same cycle. At most one ch_oe is high. No enable rises less than TURN_CYC cycles after any enable falls.
- Inputs are sampled only on clk rising edge; no combinational path from inputs to outputs.
- Reset mid-transfer drops all enables immediately (asynchronous).

Decomposition:
- Shared package bimux_pkg:
  - state enum (IDLE, TURN, ACTIVE)
  - DIR_NORMAL=0 / DIR_REVERSE=1 constants
  - turn counter width constant (4 bits)
- One natural sub-module: bimux_route_fsm (state, turn counter, latches, legality check, grant/err/oe generation). The top level holds the data registers and the beat counter.

Test Plan:
- Reset and normal route. Reset low 3 cycles, then N=8, TURN_CYC=1, req=1, dir=0, sel=5, ch_i[5]=8'hA5 -> 1 TURN cycle with all oe=0. Then grant=1, com_oe=1, com_o=8'hA5 one cycle after sampling; beat_cnt counts 1,2,3.
- Reverse route. dir=1, sel=2, com_i=8'h3C -> ch_oe=8'b00000100, ch_o[2]=8'h3C, all other ch_o slices 0, com_oe=0.
- Hot redirect. While ACTIVE on sel=2, change to sel=6 with req held and TURN_CYC=3 -> enables low for exactly 3 cycles, grant=0 during the gap. Then ch_oe=8'b01000000 and beat_cnt restarts from 1.
- Illegal select. N=6, req=1, sel=7 -> err pulses every cycle while held; grant=0, all oe=0, state stays IDLE.
- Release and abort. Drop req in ACTIVE -> grant and oe low next cycle. Drop req in TURN -> return to IDLE, no grant ever asserted.
- Async reset mid-transfer. Assert rst_n=0 between clock edges while ACTIVE -> com_oe, ch_oe and grant fall immediately, without waiting for a clock edge. Continuously check the enable mutual-exclusion assertion throughout.
